// File: rtl/wimax_pkg.sv
// Shared WiMAX interleaver definitions: block geometry and the ping-pong bank type.
package wimax_pkg;
    localparam int BLOCK_LEN = 192;
    localparam int ADDR_W    = 9;
    typedef logic bank_t;
endpackage

// File: rtl/mod_counter.sv
// Modulo-LIMIT address counter with a combinational wrap pulse on the terminal count.
module mod_counter #(
    parameter int LIMIT = 192,
    parameter int W     = 9
) (
    input  logic         clk,
    input  logic         resetN,
    input  logic         clear,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap
);
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    // The wrap pulse is combinational so the parent can act on it in the same edge.
    assign wrap = en & (count == LAST);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (en)
            count <= wrap ? '0 : count + 1'b1;
    end
endmodule

// File: rtl/ppbuf_ctrl.sv
// Ping-pong buffer controller: fills one RAM bank while the other is streamed to the interleaver.
module ppbuf_ctrl
    import wimax_pkg::*;
#(
    parameter int BLOCK_LEN = wimax_pkg::BLOCK_LEN,
    parameter int ADDR_W    = wimax_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              flush,
    input  logic              valid_in,
    output logic              ready_out,
    output logic              wr_en,
    output bank_t             wr_bank,
    output logic [ADDR_W-1:0] wraddress,
    output logic              rd_en,
    output bank_t             rd_bank,
    output logic [ADDR_W-1:0] rdaddress,
    output logic              valid_out,
    input  logic              ready_in,
    output logic              last_out,
    output logic [1:0]        bank_full
);
    // Handshake: a beat transfers on an edge where valid and ready are both high;
    // valid_out/last_out (and the RAM q) hold while valid_out=1 and ready_in=0.
    logic       wr_wrap;
    logic       rd_wrap;
    logic [1:0] full_nxt;

    assign ready_out = ~bank_full[wr_bank] & ~flush;
    assign wr_en     = valid_in & ready_out;
    assign rd_en     = bank_full[rd_bank] & (~valid_out | ready_in) & ~flush;

    mod_counter #(.LIMIT(BLOCK_LEN), .W(ADDR_W)) u_wr_cnt (
        .clk    (clk),
        .resetN (resetN),
        .clear  (flush),
        .en     (wr_en),
        .count  (wraddress),
        .wrap   (wr_wrap)
    );

    mod_counter #(.LIMIT(BLOCK_LEN), .W(ADDR_W)) u_rd_cnt (
        .clk    (clk),
        .resetN (resetN),
        .clear  (flush),
        .en     (rd_en),
        .count  (rdaddress),
        .wrap   (rd_wrap)
    );

    // Clear is applied before set so a same-edge release and refill of one bank ends full.
    always_comb begin
        full_nxt = bank_full;
        if (rd_wrap)
            full_nxt[rd_bank] = 1'b0;
        if (wr_wrap)
            full_nxt[wr_bank] = 1'b1;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            bank_full <= 2'b00;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
        end else if (flush) begin
            bank_full <= 2'b00;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
        end else begin
            bank_full <= full_nxt;
            if (wr_wrap)
                wr_bank <= ~wr_bank;
            if (rd_wrap)
                rd_bank <= ~rd_bank;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            valid_out <= 1'b0;
            last_out  <= 1'b0;
        end else if (flush) begin
            valid_out <= 1'b0;
            last_out  <= 1'b0;
        end else if (~valid_out | ready_in) begin
            valid_out <= rd_en;
            last_out  <= rd_wrap;
        end
    end
endmodule
